// File: rtl/dummy_pkg.sv
// Shared types and default constants for the event scanner slice.
// Also carries the index-width helper used to size channel indices.
package dummy_pkg;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam int unsigned DefaultNumChannels   = 8;
  localparam int unsigned DefaultCntWidth      = 16;
  localparam int unsigned DefaultStartupCycles = 1000;

  // Same contract as cf_math_pkg::idx_width: at least one bit, even for a single entry.
  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
  endfunction

endpackage

// File: rtl/dummy_event_scanner_if.sv
// Output-event handshake between the scanner (master) and its consumer (slave).
interface dummy_event_scanner_if #(
  parameter int unsigned IdxWidth = dummy_pkg::idx_width(dummy_pkg::DefaultNumChannels)
) ();

  logic                evt_valid_o;
  logic [IdxWidth-1:0] evt_idx_o;
  logic                evt_ready_i;

  modport master (
    output evt_valid_o,
    output evt_idx_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_idx_o,
    output evt_ready_i
  );

endinterface

// File: rtl/dummy_event_scanner_lzc.sv
// Leading/trailing zero counter with the common_cells lzc interface.
// MODE=0 yields the index of the lowest set bit, MODE=1 the count of leading zeros.
module lzc
  import dummy_pkg::*;
#(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  logic [WIDTH-1:0]     in_ordered;
  logic [CNT_WIDTH-1:0] chain [WIDTH];

  // Reversing the input turns a leading-zero count into a lowest-set-bit search.
  for (genvar g = 0; g < WIDTH; g++) begin : g_order
    if (MODE) begin : g_rev
      assign in_ordered[g] = in_i[WIDTH-1-g];
    end else begin : g_fwd
      assign in_ordered[g] = in_i[g];
    end
  end

  assign chain[WIDTH-1] = in_ordered[WIDTH-1] ? CNT_WIDTH'(WIDTH-1) : '0;

  for (genvar g = 0; g < WIDTH-1; g++) begin : g_chain
    assign chain[g] = in_ordered[g] ? CNT_WIDTH'(g) : chain[g+1];
  end

  assign cnt_o   = chain[0];
  assign empty_o = ~|in_i;

endmodule

// File: rtl/dummy_event_scanner.sv
// Collects single-cycle event strobes into a pending set and emits them one at a
// time, lowest channel first, over a valid/ready handshake; counts dropped events.
module dummy_event_scanner
  import dummy_pkg::*;
#(
  parameter int unsigned NumChannels   = DefaultNumChannels,
  parameter int unsigned CntWidth      = DefaultCntWidth,
  parameter int unsigned StartupCycles = DefaultStartupCycles
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [NumChannels-1:0] evt_i,
  dummy_event_scanner_if.master  evt_if,
  output logic [NumChannels-1:0] pending_o,
  output logic                   alive_o,
  output logic [CntWidth-1:0]    drop_cnt_o
);

  localparam int unsigned IdxWidth = idx_width(NumChannels);
  localparam int unsigned SuWidth  = (StartupCycles > 1) ? $clog2(StartupCycles) : 1;
  localparam int unsigned PopWidth = $clog2(NumChannels + 1);
  localparam int unsigned SumWidth = CntWidth + PopWidth;
  localparam logic [NumChannels-1:0] OneLsb = NumChannels'(1);

  state_e               state_q, state_d;
  logic [SuWidth-1:0]   su_cnt_q, su_cnt_d;
  logic [NumChannels-1:0] pending_q, pending_d;
  logic [NumChannels-1:0] clr_mask, drop_vec;
  logic                 valid_q, valid_d;
  logic [IdxWidth-1:0]  idx_q, idx_d;
  logic                 alive_q;
  logic [CntWidth-1:0]  drop_q, drop_d;
  logic [PopWidth-1:0]  drop_num;
  logic [SumWidth-1:0]  drop_sum;
  logic [IdxWidth-1:0]  lzc_cnt;
  logic                 lzc_empty;
  logic                 handshake, load;

  lzc #(
    .WIDTH (NumChannels),
    .MODE  (1'b0)
  ) u_lzc (
    .in_i    (pending_q),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  // Startup runs for a fixed number of cycles; afterwards enable_i toggles RUN/HOLD.
  always_comb begin
    state_d  = state_q;
    su_cnt_d = su_cnt_q;
    unique case (state_q)
      STARTUP: begin
        if (su_cnt_q == SuWidth'(StartupCycles - 1)) begin
          state_d = RUN;
        end else begin
          su_cnt_d = su_cnt_q + SuWidth'(1);
        end
      end
      RUN:     if (!enable_i) state_d = HOLD;
      HOLD:    if (enable_i)  state_d = RUN;
      default: state_d = STARTUP;
    endcase
  end

  // A bit being handed to the output this cycle is free to be re-armed by a new strobe.
  always_comb begin
    handshake = valid_q & evt_if.evt_ready_i;
    load      = (state_q == RUN) & (~valid_q | handshake) & ~lzc_empty;
    clr_mask  = load ? (OneLsb << lzc_cnt) : '0;
    drop_vec  = evt_i & pending_q & ~clr_mask;
    pending_d = (pending_q & ~clr_mask) | evt_i;

    valid_d = valid_q;
    idx_d   = idx_q;
    if (load) begin
      valid_d = 1'b1;
      idx_d   = lzc_cnt;
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    drop_num = PopWidth'($countones(drop_vec));
    drop_sum = SumWidth'(drop_q) + SumWidth'(drop_num);
    drop_d   = (|drop_sum[SumWidth-1:CntWidth]) ? '1 : drop_sum[CntWidth-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= STARTUP;
      su_cnt_q  <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      alive_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      su_cnt_q  <= su_cnt_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      alive_q   <= alive_q | (state_d != STARTUP);
      drop_q    <= drop_d;
    end
  end

  assign evt_if.evt_valid_o = valid_q;
  assign evt_if.evt_idx_o   = idx_q;
  assign pending_o          = pending_q;
  assign alive_o            = alive_q;
  assign drop_cnt_o         = drop_q;

endmodule

// File: tb/tb_dummy_event_scanner.sv
// Self-checking bench: directed scenarios against fixed expectations plus a
// randomized run against a cycle-level behavioural model of the scanner.
module tb_dummy_event_scanner;

  localparam int unsigned Sc = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] evt;
  logic       ready;

  logic [7:0]  pending_a, pending_b;
  logic        alive_a, alive_b;
  logic [15:0] drop_a;
  logic [1:0]  drop_b;

  int errors = 0;
  int checks = 0;

  dummy_event_scanner_if #(.IdxWidth(3)) if_a ();
  dummy_event_scanner_if #(.IdxWidth(3)) if_b ();

  assign if_a.evt_ready_i = ready;
  assign if_b.evt_ready_i = ready;

  dummy_event_scanner #(.NumChannels(8), .CntWidth(16), .StartupCycles(Sc)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .evt_i(evt), .evt_if(if_a),
    .pending_o(pending_a), .alive_o(alive_a), .drop_cnt_o(drop_a)
  );

  dummy_event_scanner #(.NumChannels(8), .CntWidth(2), .StartupCycles(Sc)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .evt_i(evt), .evt_if(if_b),
    .pending_o(pending_b), .alive_o(alive_b), .drop_cnt_o(drop_b)
  );

  always #5 clk = ~clk;

  // Behavioural model: started after Sc released cycles, then paused whenever
  // enable was low on the previous edge; emits lowest pending channel when free.
  bit         m_started, m_hold, m_valid;
  int         m_age, m_idx, m_drops;
  logic [7:0] m_pend;
  bit         m_hs, m_ld;
  int         m_lo;
  logic [7:0] m_nxt;

  always @(posedge clk) begin
    if (rst) begin
      m_started = 0; m_hold = 0; m_valid = 0;
      m_age = 0; m_idx = 0; m_drops = 0; m_pend = 8'h00;
    end else begin
      m_hs = m_valid && ready;
      m_lo = -1;
      for (int b = 7; b >= 0; b--) if (m_pend[b]) m_lo = b;
      m_ld = m_started && !m_hold && (!m_valid || m_hs) && (m_lo >= 0);
      m_nxt = m_pend;
      if (m_ld) m_nxt[m_lo] = 1'b0;
      for (int b = 0; b < 8; b++) begin
        if (evt[b]) begin
          if (m_nxt[b]) m_drops++;
          m_nxt[b] = 1'b1;
        end
      end
      m_pend = m_nxt;
      if (m_ld) begin
        m_valid = 1;
        m_idx   = m_lo;
      end else if (m_hs) begin
        m_valid = 0;
      end
      if (m_started) m_hold = !enable;
      else if (m_age == int'(Sc) - 1) begin
        m_started = 1;
        m_hold    = 0;
      end else m_age++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_run();
    rst = 1; evt = 8'h00; enable = 1; ready = 0;
    tick(); tick();
    rst = 0;
    repeat (Sc) tick();
  endtask

  task automatic test_reset();
    rst = 1; enable = 1; ready = 1; evt = 8'hFF;
    tick(); tick();
    checks++; if (if_a.evt_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", if_a.evt_valid_o); end
    checks++; if (if_a.evt_idx_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d expected 0", if_a.evt_idx_o); end
    checks++; if (pending_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_pending: got %0h expected 0", pending_a); end
    checks++; if (alive_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_alive: got %0b expected 0", alive_a); end
    checks++; if (drop_a !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d expected 0", drop_a); end
    checks++; if (drop_b !== 2'd0) begin errors++; $display("[TB] FAIL reset_drop_narrow: got %0d expected 0", drop_b); end
    evt = 8'h00;
  endtask

  task automatic test_startup();
    int c;
    rst = 1; evt = 8'h00; enable = 1; ready = 1;
    tick();
    rst = 0;
    for (int cyc = 0; cyc <= 17; cyc++) begin
      evt = (cyc == 3) ? 8'h10 : 8'h00;
      tick();
      c = cyc + 1;
      checks++; if (alive_a !== (c >= 16)) begin errors++; $display("[TB] FAIL startup_alive c%0d: got %0b expected %0b", c, alive_a, (c >= 16)); end
      if (c <= 16) begin
        checks++; if (if_a.evt_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL startup_no_valid c%0d: got %0b expected 0", c, if_a.evt_valid_o); end
      end
      if (c == 4) begin
        checks++; if (pending_a !== 8'h10) begin errors++; $display("[TB] FAIL startup_pending: got %0h expected 10", pending_a); end
      end
      if (c == 17) begin
        checks++; if (if_a.evt_valid_o !== 1'b1 || if_a.evt_idx_o !== 3'd4) begin errors++; $display("[TB] FAIL startup_first_evt: got v%0b i%0d expected v1 i4", if_a.evt_valid_o, if_a.evt_idx_o); end
      end
      if (c == 18) begin
        checks++; if (if_a.evt_valid_o !== 1'b0 || pending_a !== 8'h00) begin errors++; $display("[TB] FAIL startup_drain: got v%0b p%0h expected v0 p0", if_a.evt_valid_o, pending_a); end
      end
    end
  endtask

  task automatic test_ordering();
    logic [2:0] exp_idx [3] = '{3'd2, 3'd5, 3'd7};
    start_run();
    ready = 1;
    evt = 8'hA4; tick(); evt = 8'h00;
    checks++; if (pending_a !== 8'hA4) begin errors++; $display("[TB] FAIL order_pending: got %0h expected a4", pending_a); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if_a.evt_valid_o !== 1'b1 || if_a.evt_idx_o !== exp_idx[i]) begin errors++; $display("[TB] FAIL order_idx%0d: got v%0b i%0d expected v1 i%0d", i, if_a.evt_valid_o, if_a.evt_idx_o, exp_idx[i]); end
    end
    tick();
    checks++; if (if_a.evt_valid_o !== 1'b0 || pending_a !== 8'h00) begin errors++; $display("[TB] FAIL order_end: got v%0b p%0h expected v0 p0", if_a.evt_valid_o, pending_a); end
  endtask

  task automatic test_stability();
    start_run();
    ready = 0;
    evt = 8'h20; tick(); evt = 8'h00; tick();
    checks++; if (if_a.evt_valid_o !== 1'b1 || if_a.evt_idx_o !== 3'd5) begin errors++; $display("[TB] FAIL stab_first: got v%0b i%0d expected v1 i5", if_a.evt_valid_o, if_a.evt_idx_o); end
    evt = 8'h02; tick(); evt = 8'h00;
    checks++; if (pending_a !== 8'h02) begin errors++; $display("[TB] FAIL stab_pending: got %0h expected 02", pending_a); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (if_a.evt_valid_o !== 1'b1 || if_a.evt_idx_o !== 3'd5) begin errors++; $display("[TB] FAIL stab_hold%0d: got v%0b i%0d expected v1 i5", i, if_a.evt_valid_o, if_a.evt_idx_o); end
      tick();
    end
    ready = 1; tick();
    checks++; if (if_a.evt_valid_o !== 1'b1 || if_a.evt_idx_o !== 3'd1) begin errors++; $display("[TB] FAIL stab_next: got v%0b i%0d expected v1 i1", if_a.evt_valid_o, if_a.evt_idx_o); end
    tick();
    checks++; if (if_a.evt_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL stab_drain: got %0b expected 0", if_a.evt_valid_o); end
  endtask

  task automatic test_drops();
    start_run();
    ready = 0;
    evt = 8'h01; tick(); evt = 8'h00; tick();
    checks++; if (if_a.evt_valid_o !== 1'b1 || if_a.evt_idx_o !== 3'd0) begin errors++; $display("[TB] FAIL drop_busy: got v%0b i%0d expected v1 i0", if_a.evt_valid_o, if_a.evt_idx_o); end
    repeat (4) begin evt = 8'h08; tick(); evt = 8'h00; tick(); end
    checks++; if (pending_a !== 8'h08) begin errors++; $display("[TB] FAIL drop_pending: got %0h expected 08", pending_a); end
    checks++; if (drop_a !== 16'd3) begin errors++; $display("[TB] FAIL drop_count3: got %0d expected 3", drop_a); end
    checks++; if (drop_b !== 2'd3) begin errors++; $display("[TB] FAIL drop_narrow3: got %0d expected 3", drop_b); end
    repeat (7) begin evt = 8'h08; tick(); evt = 8'h00; tick(); end
    checks++; if (drop_a !== 16'd10) begin errors++; $display("[TB] FAIL drop_count10: got %0d expected 10", drop_a); end
    checks++; if (drop_b !== 2'd3) begin errors++; $display("[TB] FAIL drop_narrow_sat: got %0d expected 3", drop_b); end
    evt = 8'hF0; tick(); tick(); evt = 8'h00; tick();
    checks++; if (drop_a !== 16'd14) begin errors++; $display("[TB] FAIL drop_popcount: got %0d expected 14", drop_a); end
    checks++; if (pending_a !== 8'hF8) begin errors++; $display("[TB] FAIL drop_pending_f8: got %0h expected f8", pending_a); end
    ready = 1; evt = 8'h08; tick(); ready = 0; evt = 8'h00;
    checks++; if (if_a.evt_valid_o !== 1'b1 || if_a.evt_idx_o !== 3'd3) begin errors++; $display("[TB] FAIL drop_clear_idx: got v%0b i%0d expected v1 i3", if_a.evt_valid_o, if_a.evt_idx_o); end
    checks++; if (pending_a !== 8'hF8) begin errors++; $display("[TB] FAIL drop_clear_rearm: got %0h expected f8", pending_a); end
    checks++; if (drop_a !== 16'd14) begin errors++; $display("[TB] FAIL drop_clear_nodrop: got %0d expected 14", drop_a); end
  endtask

  task automatic test_hold();
    start_run();
    ready = 1; enable = 0; tick();
    evt = 8'h0F; tick(); evt = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checks++; if (if_a.evt_valid_o !== 1'b0 || pending_a !== 8'h0F) begin errors++; $display("[TB] FAIL hold_idle%0d: got v%0b p%0h expected v0 p0f", i, if_a.evt_valid_o, pending_a); end
      tick();
    end
    enable = 1; tick();
    checks++; if (if_a.evt_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL hold_resume_lat: got %0b expected 0", if_a.evt_valid_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (if_a.evt_valid_o !== 1'b1 || if_a.evt_idx_o !== 3'(k)) begin errors++; $display("[TB] FAIL hold_emit%0d: got v%0b i%0d expected v1 i%0d", k, if_a.evt_valid_o, if_a.evt_idx_o, k); end
    end
    tick();
    checks++; if (if_a.evt_valid_o !== 1'b0 || pending_a !== 8'h00) begin errors++; $display("[TB] FAIL hold_end: got v%0b p%0h expected v0 p0", if_a.evt_valid_o, pending_a); end
  endtask

  task automatic test_reset_midstream();
    start_run();
    ready = 0;
    evt = 8'hF1; tick(); evt = 8'h00; tick();
    checks++; if (if_a.evt_valid_o !== 1'b1 || pending_a !== 8'hF0) begin errors++; $display("[TB] FAIL mid_setup: got v%0b p%0h expected v1 pf0", if_a.evt_valid_o, pending_a); end
    rst = 1; evt = 8'hFF; ready = 1; tick();
    checks++; if (if_a.evt_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %0b expected 0", if_a.evt_valid_o); end
    checks++; if (if_a.evt_idx_o !== 3'd0) begin errors++; $display("[TB] FAIL mid_idx: got %0d expected 0", if_a.evt_idx_o); end
    checks++; if (pending_a !== 8'h00) begin errors++; $display("[TB] FAIL mid_pending: got %0h expected 0", pending_a); end
    checks++; if (alive_a !== 1'b0) begin errors++; $display("[TB] FAIL mid_alive: got %0b expected 0", alive_a); end
    checks++; if (drop_a !== 16'd0) begin errors++; $display("[TB] FAIL mid_drop: got %0d expected 0", drop_a); end
    rst = 0; evt = 8'h00; ready = 0;
  endtask

  task automatic test_random();
    int exp_a, exp_b;
    start_run();
    for (int i = 0; i < 600; i++) begin
      evt    = 8'($urandom & $urandom & $urandom);
      ready  = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      rst    = ($urandom_range(0, 199) == 0);
      tick();
      exp_a = (m_drops > 65535) ? 65535 : m_drops;
      exp_b = (m_drops > 3) ? 3 : m_drops;
      checks++; if (if_a.evt_valid_o !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %0b expected %0b", i, if_a.evt_valid_o, m_valid); end
      checks++; if (if_a.evt_idx_o !== 3'(m_idx)) begin errors++; $display("[TB] FAIL rnd_idx@%0d: got %0d expected %0d", i, if_a.evt_idx_o, m_idx); end
      checks++; if (pending_a !== m_pend) begin errors++; $display("[TB] FAIL rnd_pending@%0d: got %0h expected %0h", i, pending_a, m_pend); end
      checks++; if (alive_a !== m_started) begin errors++; $display("[TB] FAIL rnd_alive@%0d: got %0b expected %0b", i, alive_a, m_started); end
      checks++; if (drop_a !== 16'(exp_a)) begin errors++; $display("[TB] FAIL rnd_drop@%0d: got %0d expected %0d", i, drop_a, exp_a); end
      checks++; if (drop_b !== 2'(exp_b)) begin errors++; $display("[TB] FAIL rnd_drop_narrow@%0d: got %0d expected %0d", i, drop_b, exp_b); end
      checks++; if (if_b.evt_valid_o !== m_valid || pending_b !== m_pend || alive_b !== m_started) begin errors++; $display("[TB] FAIL rnd_narrow_out@%0d: got v%0b p%0h a%0b expected v%0b p%0h a%0b", i, if_b.evt_valid_o, pending_b, alive_b, m_valid, m_pend, m_started); end
    end
    rst = 0; evt = 8'h00;
  endtask

  initial begin
    rst = 1; enable = 0; evt = 8'h00; ready = 0;
    test_reset();
    test_startup();
    test_ordering();
    test_stability();
    test_drops();
    test_hold();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dummy_event_scanner.md
DUMMY_EVENT_SCANNER -- requirements
Module: dummy_event_scanner

Interface
REQ-001 SHALL have parameter NumChannels, default 8, number of event channels (>= 2).
REQ-002 SHALL have parameter CntWidth, default 16, width of the drop counter.
REQ-003 SHALL have parameter StartupCycles, default 1000, cycles from reset release to alive_o assertion (>= 1).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable_i  input  1  permits emission of events when high.
REQ-007 SHALL have port evt_i  input  NumChannels  per-channel single-cycle event strobes.
REQ-008 SHALL have port evt_valid_o  output  1  output event valid.
REQ-009 SHALL have port evt_idx_o  output  IdxWidth  channel index of output event, IdxWidth = cf_math_pkg::idx_width(NumChannels).
REQ-010 SHALL have port evt_ready_i  input  1  consumer ready.
REQ-011 SHALL have port pending_o  output  NumChannels  current pending vector.
REQ-012 SHALL have port alive_o  output  1  startup complete, sticky until reset.
REQ-013 SHALL have port drop_cnt_o  output  CntWidth  saturating count of dropped events.

Function
REQ-014 SHALL use FSM states STARTUP, RUN, HOLD; STARTUP -> RUN when startup counter reaches StartupCycles-1; RUN -> HOLD when enable_i low; HOLD -> RUN when enable_i high.
REQ-015 SHALL assert alive_o registered in the first cycle in RUN or HOLD, and keep it high until reset.
REQ-016 SHALL capture evt_i bits into pending register in every state, including STARTUP (pending visible next cycle).
REQ-017 SHALL count a drop when an evt_i bit arrives while the same pending bit is already set and is not being cleared that cycle; multiple drops in one cycle add popcount; counter saturates at all-ones.
REQ-018 SHALL load the output register, in RUN only, when it is empty or a handshake (evt_valid_o && evt_ready_i) occurs that cycle, with the lowest-index set pending bit (lzc, trailing-zero mode), clearing that bit.
REQ-019 SHALL hold evt_valid_o and evt_idx_o stable until handshake; a lower-index arrival never changes a presented index.
REQ-020 SHALL give latency: evt_i at cycle t -> pending_o at t+1 -> evt_valid_o at t+2 if output empty and RUN.
REQ-021 SHALL treat an event on the bit being cleared in the same cycle as a new pending event, not a drop.
REQ-022 SHALL, in HOLD or STARTUP, not load new output; an already-valid output stays presented and may complete its handshake.
REQ-023 SHALL, with pending empty, deassert evt_valid_o after handshake (no bubble-free requirement beyond REQ-018 back-to-back).
REQ-024 SHALL sustain one event per cycle when evt_ready_i held high and pending non-empty.

Reset
REQ-025 SHALL, while rst_i high at a clock edge, set state STARTUP, startup counter 0, pending 0, evt_valid_o 0, evt_idx_o 0, alive_o 0, drop_cnt_o 0.
REQ-026 SHALL discard evt_i and any in-flight output on reset mid-operation; no handshake completes in a reset cycle.

Structure
REQ-027 SHALL place the FSM state enum and default parameter constants in shared package dummy_pkg.
REQ-028 SHALL instantiate common_cells lzc (WIDTH=NumChannels, MODE=0) as the single sub-module; no other sub-modules.

Verification
REQ-029 SHALL verify startup: StartupCycles=16, reset released cycle 0 -> alive_o high at cycle 16, no evt_valid_o before it.
REQ-030 SHALL verify ordering: evt_i=8'b1010_0100 once in RUN, ready high -> indices 2,5,7 on consecutive cycles.
REQ-031 SHALL verify stability: idx 5 presented, ready low, then evt_i[1] -> evt_idx_o stays 5 until handshake, then 1.
REQ-032 SHALL verify drops: evt_i[3] pulsed 4 times while pending[3] set and ready low -> drop_cnt_o=3; CntWidth=2, 10 drops -> saturates at 3.
REQ-033 SHALL verify HOLD: enable_i low with pending 8'h0F -> no new valids; enable_i high -> indices 0..3 emitted.
REQ-034 SHALL verify reset mid-stream: rst_i pulsed with valid high and pending 8'hF0 -> all outputs zero next cycle, alive_o low.
